// File: rtl/mii_rx_byte_assembler.sv
// rtl/mii_rx_byte_assembler.sv - MII nibble-to-byte assembler with per-frame status
//
// Pairs 4-bit MII receive nibbles (low nibble first) into bytes for the
// downstream packet detector and reports per-frame status.
//
// Parameters:
//   MAX_BYTES  - largest legal frame in bytes, preamble and SFD included
//   CNT_W      - width of byte_count (2**CNT_W must exceed MAX_BYTES)
//
// Ports:
//   clock       - system clock, one nibble per cycle
//   reset       - asynchronous active-high reset
//   rxd         - MII receive nibble
//   rx_dv       - MII receive data valid
//   rx_er       - MII receive error
//   data        - assembled byte, held until the next byte_strobe
//   control     - frame active level for the detector
//   byte_strobe - one-cycle pulse when data carries a new byte
//   byte_count  - bytes delivered in the current or last frame (saturating)
//   frame_done  - one-cycle pulse at frame end, clean or not
//   frame_error - sticky per frame: rx_er, dribble nibble or oversize
//   oversize    - sticky per frame: frame grew beyond MAX_BYTES
//
// Optional build macro MII_RX_SFD_ALIGN_EN: when defined, a 0xD/0x5 nibble
// pair seen before the SFD in the HI state shifts the nibble phase by one.

module mii_rx_byte_assembler #(
    parameter int MAX_BYTES = 1530,
    parameter int CNT_W     = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       rxd,
    input  logic             rx_dv,
    input  logic             rx_er,
    output logic [7:0]       data,
    output logic             control,
    output logic             byte_strobe,
    output logic [CNT_W-1:0] byte_count,
    output logic             frame_done,
    output logic             frame_error,
    output logic             oversize
);

    typedef enum logic [1:0] {IDLE, LO, HI, DRAIN} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    state_t     state;
    logic [3:0] held_low;
    logic       realign_hit;

`ifdef MII_RX_SFD_ALIGN_EN
    logic sfd_seen;

    // A 0xD held as low nibble followed by 0x5 means the pairing is one
    // nibble late relative to the SFD; slide the phase instead of emitting.
    assign realign_hit = !sfd_seen && (held_low == 4'hD) && (rxd == 4'h5);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sfd_seen <= 1'b0;
        end else if (state == IDLE && rx_dv) begin
            sfd_seen <= 1'b0;
        end else if (state == HI && rx_dv && !rx_er && !realign_hit
                     && byte_count != MAX_CNT && {rxd, held_low} == 8'hD5) begin
            sfd_seen <= 1'b1;
        end
    end
`else
    assign realign_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            held_low    <= 4'h0;
            data        <= 8'h00;
            control     <= 1'b0;
            byte_strobe <= 1'b0;
            byte_count  <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            oversize    <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_dv) begin
                        byte_count <= '0;
                        oversize   <= 1'b0;
                        control    <= 1'b0;
                        if (rx_er) begin
                            frame_error <= 1'b1;
                            state       <= DRAIN;
                        end else begin
                            frame_error <= 1'b0;
                            held_low    <= rxd;
                            state       <= HI;
                        end
                    end
                end
                LO: begin
                    if (!rx_dv) begin
                        frame_done <= 1'b1;
                        control    <= 1'b0;
                        state      <= IDLE;
                    end else if (rx_er) begin
                        frame_error <= 1'b1;
                        control     <= 1'b0;
                        state       <= DRAIN;
                    end else begin
                        held_low <= rxd;
                        state    <= HI;
                    end
                end
                HI: begin
                    if (!rx_dv) begin
                        // Dribble: odd nibble count, the half byte is dropped.
                        held_low    <= 4'h0;
                        frame_error <= 1'b1;
                        frame_done  <= 1'b1;
                        control     <= 1'b0;
                        state       <= IDLE;
                    end else if (rx_er) begin
                        frame_error <= 1'b1;
                        control     <= 1'b0;
                        state       <= DRAIN;
                    end else if (realign_hit) begin
                        held_low <= rxd;
                    end else if (byte_count == MAX_CNT) begin
                        // This byte would exceed the limit: suppress it.
                        oversize    <= 1'b1;
                        frame_error <= 1'b1;
                        control     <= 1'b0;
                        state       <= DRAIN;
                    end else begin
                        data        <= {rxd, held_low};
                        byte_strobe <= 1'b1;
                        control     <= 1'b1;
                        if (byte_count != {CNT_W{1'b1}}) begin
                            byte_count <= byte_count + 1'b1;
                        end
                        state <= LO;
                    end
                end
                DRAIN: begin
                    control <= 1'b0;
                    if (!rx_dv) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mii_rx_byte_assembler.sv
// tb/tb_mii_rx_byte_assembler.sv - directed self-checking bench for mii_rx_byte_assembler

module tb_mii_rx_byte_assembler;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  rxd;
    logic        rx_dv;
    logic        rx_er;

    logic [7:0]  data,        data_s;
    logic        control,     control_s;
    logic        byte_strobe, byte_strobe_s;
    logic [10:0] byte_count,  byte_count_s;
    logic        frame_done,  frame_done_s;
    logic        frame_error, frame_error_s;
    logic        oversize,    oversize_s;

    int passed = 0;
    int total  = 0;

    int strobes = 0, dones = 0, strobes_s = 0, dones_s = 0;
    logic [7:0] bytes[$];
    logic [7:0] last_s = 8'h00;

    always #5 clock = ~clock;

    mii_rx_byte_assembler dut (
        .clock(clock), .reset(reset), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
        .data(data), .control(control), .byte_strobe(byte_strobe),
        .byte_count(byte_count), .frame_done(frame_done),
        .frame_error(frame_error), .oversize(oversize)
    );

    mii_rx_byte_assembler #(.MAX_BYTES(8), .CNT_W(11)) dut_s (
        .clock(clock), .reset(reset), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
        .data(data_s), .control(control_s), .byte_strobe(byte_strobe_s),
        .byte_count(byte_count_s), .frame_done(frame_done_s),
        .frame_error(frame_error_s), .oversize(oversize_s)
    );

    always @(negedge clock) begin
        if (byte_strobe) begin
            strobes++;
            bytes.push_back(data);
        end
        if (frame_done) dones++;
        if (byte_strobe_s) begin
            strobes_s++;
            last_s = data_s;
        end
        if (frame_done_s) dones_s++;
    end

    function automatic logic [7:0] pay(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    task automatic drive(input logic [3:0] v, input logic dv, input logic er);
        rxd = v; rx_dv = dv; rx_er = er;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'h0, 1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(b[3:0], 1'b1, 1'b0);
        drive(b[7:4], 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1; rxd = 4'h0; rx_dv = 1'b0; rx_er = 1'b0;
        #1;
        total++; if (data !== 8'h00)        $display("FAIL reset_data got %h exp 00", data); else passed++;
        total++; if (control !== 1'b0)      $display("FAIL reset_control got %b exp 0", control); else passed++;
        total++; if (byte_strobe !== 1'b0)  $display("FAIL reset_strobe got %b exp 0", byte_strobe); else passed++;
        total++; if (byte_count !== 11'd0)  $display("FAIL reset_count got %0d exp 0", byte_count); else passed++;
        total++; if (frame_done !== 1'b0)   $display("FAIL reset_done got %b exp 0", frame_done); else passed++;
        total++; if (frame_error !== 1'b0)  $display("FAIL reset_error got %b exp 0", frame_error); else passed++;
        total++; if (oversize !== 1'b0)     $display("FAIL reset_oversize got %b exp 0", oversize); else passed++;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2);
    endtask

    // 7 x 0x55 preamble bytes, SFD, 30 payload bytes; optional dribble nibble.
    task automatic run_std_frame(input logic dribble, output int cbad);
        cbad = 0;
        for (int i = 0; i < 14; i++) begin
            drive(4'h5, 1'b1, 1'b0);
            if (i >= 1 && control !== 1'b1) cbad++;
        end
        drive(4'h5, 1'b1, 1'b0);
        if (control !== 1'b1) cbad++;
        drive(4'hD, 1'b1, 1'b0);
        if (control !== 1'b1) cbad++;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            b = pay(i);
            drive(b[3:0], 1'b1, 1'b0);
            if (control !== 1'b1) cbad++;
            drive(b[7:4], 1'b1, 1'b0);
            if (control !== 1'b1) cbad++;
        end
        if (dribble) drive(4'hA, 1'b1, 1'b0);
        idle(3);
    endtask

    task automatic test_clean_frame;
        int s0, d0, b0, cbad, bbad;
        s0 = strobes; d0 = dones; b0 = bytes.size();
        run_std_frame(1'b0, cbad);
        bbad = 0;
        for (int i = 0; i < 38; i++) begin
            logic [7:0] e;
            e = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : pay(i - 8);
            if (b0 + i >= bytes.size()) bbad++;
            else if (bytes[b0 + i] !== e) bbad++;
        end
        total++; if (strobes - s0 != 38)    $display("FAIL clean_strobes got %0d exp 38", strobes - s0); else passed++;
        total++; if (bbad != 0)             $display("FAIL clean_bytes got %0d wrong bytes exp 0", bbad); else passed++;
        total++; if (cbad != 0)             $display("FAIL clean_control got %0d low cycles exp 0", cbad); else passed++;
        total++; if (byte_count !== 11'd38) $display("FAIL clean_count got %0d exp 38", byte_count); else passed++;
        total++; if (dones - d0 != 1)       $display("FAIL clean_done got %0d pulses exp 1", dones - d0); else passed++;
        total++; if (frame_error !== 1'b0)  $display("FAIL clean_error got %b exp 0", frame_error); else passed++;
        total++; if (oversize !== 1'b0)     $display("FAIL clean_oversize got %b exp 0", oversize); else passed++;
        total++; if (control !== 1'b0)      $display("FAIL clean_control_end got %b exp 0", control); else passed++;
    endtask

    task automatic test_dribble;
        int s0, d0, cbad;
        s0 = strobes; d0 = dones;
        run_std_frame(1'b1, cbad);
        total++; if (strobes - s0 != 38)    $display("FAIL dribble_strobes got %0d exp 38", strobes - s0); else passed++;
        total++; if (byte_count !== 11'd38) $display("FAIL dribble_count got %0d exp 38", byte_count); else passed++;
        total++; if (frame_error !== 1'b1)  $display("FAIL dribble_error got %b exp 1", frame_error); else passed++;
        total++; if (dones - d0 != 1)       $display("FAIL dribble_done got %0d pulses exp 1", dones - d0); else passed++;
    endtask

    task automatic test_rx_error;
        int s0, d0;
        s0 = strobes; d0 = dones;
        for (int i = 0; i < 5; i++) send_byte(pay(i));
        total++; if (control !== 1'b1) $display("FAIL rxer_control_before got %b exp 1", control); else passed++;
        drive(4'h3, 1'b1, 1'b1);
        total++; if (control !== 1'b0) $display("FAIL rxer_control_after got %b exp 0", control); else passed++;
        for (int i = 0; i < 5; i++) drive(4'(i), 1'b1, 1'b0);
        total++; if (dones - d0 != 0)  $display("FAIL rxer_early_done got %0d pulses exp 0", dones - d0); else passed++;
        idle(3);
        total++; if (strobes - s0 != 5)    $display("FAIL rxer_strobes got %0d exp 5", strobes - s0); else passed++;
        total++; if (byte_count !== 11'd5) $display("FAIL rxer_count got %0d exp 5", byte_count); else passed++;
        total++; if (frame_error !== 1'b1) $display("FAIL rxer_error got %b exp 1", frame_error); else passed++;
        total++; if (dones - d0 != 1)      $display("FAIL rxer_done got %0d pulses exp 1", dones - d0); else passed++;
    endtask

    task automatic test_oversize;
        int s0, ss0, ds0;
        s0 = strobes; ss0 = strobes_s; ds0 = dones_s;
        for (int i = 0; i < 8; i++) send_byte(pay(i));
        total++; if (control_s !== 1'b1) $display("FAIL ovs_control_byte8 got %b exp 1", control_s); else passed++;
        send_byte(pay(8));
        total++; if (control_s !== 1'b0)  $display("FAIL ovs_control_byte9 got %b exp 0", control_s); else passed++;
        total++; if (oversize_s !== 1'b1) $display("FAIL ovs_flag_byte9 got %b exp 1", oversize_s); else passed++;
        for (int i = 9; i < 12; i++) send_byte(pay(i));
        idle(3);
        total++; if (strobes_s - ss0 != 8)   $display("FAIL ovs_strobes got %0d exp 8", strobes_s - ss0); else passed++;
        total++; if (last_s !== pay(7))      $display("FAIL ovs_last_data got %h exp %h", last_s, pay(7)); else passed++;
        total++; if (byte_count_s !== 11'd8) $display("FAIL ovs_count got %0d exp 8", byte_count_s); else passed++;
        total++; if (frame_error_s !== 1'b1) $display("FAIL ovs_error got %b exp 1", frame_error_s); else passed++;
        total++; if (dones_s - ds0 != 1)     $display("FAIL ovs_done got %0d pulses exp 1", dones_s - ds0); else passed++;
        total++; if (strobes - s0 != 12)     $display("FAIL ovs_big_strobes got %0d exp 12", strobes - s0); else passed++;
        total++; if (oversize !== 1'b0)      $display("FAIL ovs_big_flag got %b exp 0", oversize); else passed++;
    endtask

    task automatic test_async_reset;
        int d0;
        for (int i = 0; i < 3; i++) send_byte(pay(i));
        #2;
        d0 = dones;
        reset = 1'b1; rx_dv = 1'b0; rxd = 4'h0;
        #1;
        total++; if (data !== 8'h00)       $display("FAIL areset_data got %h exp 00", data); else passed++;
        total++; if (control !== 1'b0)     $display("FAIL areset_control got %b exp 0", control); else passed++;
        total++; if (byte_count !== 11'd0) $display("FAIL areset_count got %0d exp 0", byte_count); else passed++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2);
        total++; if (dones != d0) $display("FAIL areset_no_done got %0d pulses exp 0", dones - d0); else passed++;
        for (int i = 0; i < 8; i++) send_byte(pay(i + 3));
        idle(3);
        total++; if (byte_count !== 11'd8) $display("FAIL areset_next_count got %0d exp 8", byte_count); else passed++;
        total++; if (frame_error !== 1'b0) $display("FAIL areset_next_error got %b exp 0", frame_error); else passed++;
        total++; if (dones - d0 != 1)      $display("FAIL areset_next_done got %0d pulses exp 1", dones - d0); else passed++;
    endtask

`ifdef MII_RX_SFD_ALIGN_EN
    task automatic test_sfd_align;
        int b0, bbad;
        b0 = bytes.size();
        drive(4'hD, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) drive(4'h5, 1'b1, 1'b0);
        drive(4'hD, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(pay(i));
        idle(3);
        bbad = 0;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] e;
            e = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : pay(i - 8);
            if (b0 + i >= bytes.size()) bbad++;
            else if (bytes[b0 + i] !== e) bbad++;
        end
        total++; if (bbad != 0)             $display("FAIL align_bytes got %0d wrong bytes exp 0", bbad); else passed++;
        total++; if (byte_count !== 11'd12) $display("FAIL align_count got %0d exp 12", byte_count); else passed++;
        total++; if (frame_error !== 1'b0)  $display("FAIL align_error got %b exp 0", frame_error); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_clean_frame();
        test_dribble();
        test_rx_error();
        test_oversize();
        test_async_reset();
`ifdef MII_RX_SFD_ALIGN_EN
        test_sfd_align();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
